// File: rtl/coproc_req_queue.sv
// coproc_req_queue: request/response queue to a genfifo execution unit; COPROC_QUEUE_BYPASS_EN enables zero-latency bypass
module coproc_req_queue #(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic [95:0] core_rdata_bi,
    output logic        core_ack_o,
    output logic        exu_req_o,
    output logic [95:0] exu_rdata_bo,
    input  logic        exu_ack_i,
    input  logic        exu_resp_req_i,
    input  logic [31:0] exu_resp_wdata_bi,
    output logic        core_resp_req_o,
    output logic [31:0] core_resp_wdata_bo,
    input  logic        core_resp_ack_i,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int RA = MAX_INFLIGHT > 1 ? $clog2(MAX_INFLIGHT) : 1;
`ifdef COPROC_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic [95:0] req_mem [DEPTH];
    logic [31:0] resp_mem [2**RA];
    logic [AW:0] req_wp, req_rp;
    logic [RA:0] resp_wp, resp_rp, resp_cnt, inflight;
    logic req_empty, req_full, resp_empty, resp_full, issue_ok, issue;
    logic req_push, req_pop, resp_push, resp_pop, resp_acc, resp_err, err;
    always_comb begin
        req_empty          = req_wp == req_rp;
        req_full           = (req_wp[AW] != req_rp[AW]) && (req_wp[AW-1:0] == req_rp[AW-1:0]);
        resp_cnt           = resp_wp - resp_rp;
        resp_empty         = resp_cnt == '0;
        resp_full          = resp_cnt == (RA+1)'(MAX_INFLIGHT);
        issue_ok           = inflight < (RA+1)'(MAX_INFLIGHT);
        core_ack_o         = !req_full;
        exu_req_o          = (!req_empty || (BYP && core_req_i)) && issue_ok;
        exu_rdata_bo       = (BYP && req_empty) ? core_rdata_bi : req_mem[req_rp[AW-1:0]];
        issue              = exu_req_o && exu_ack_i;
        req_pop            = issue && !req_empty;
        // a bypassed request that is taken immediately never enters the FIFO
        req_push           = core_req_i && core_ack_o && !(BYP && req_empty && issue);
        core_resp_req_o    = !resp_empty || (BYP && exu_resp_req_i);
        core_resp_wdata_bo = (BYP && resp_empty) ? exu_resp_wdata_bi : resp_mem[resp_rp[RA-1:0]];
        resp_acc           = core_resp_req_o && core_resp_ack_i;
        resp_pop           = core_resp_ack_i && !resp_empty;
        resp_push          = exu_resp_req_i && !resp_full && !(BYP && resp_empty && core_resp_ack_i);
        resp_err           = exu_resp_req_i && (resp_full || inflight == resp_cnt);
        err_o              = err;
    end
    always_ff @(posedge clk_i) begin
        if (req_push) req_mem[req_wp[AW-1:0]] <= core_rdata_bi;
        if (resp_push) resp_mem[resp_wp[RA-1:0]] <= exu_resp_wdata_bi;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_wp   <= '0;
            req_rp   <= '0;
            resp_wp  <= '0;
            resp_rp  <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (req_push) req_wp <= req_wp + (AW+1)'(1);
            if (req_pop) req_rp <= req_rp + (AW+1)'(1);
            if (resp_push) resp_wp <= resp_wp + (RA+1)'(1);
            if (resp_pop) resp_rp <= resp_rp + (RA+1)'(1);
            inflight <= inflight + (RA+1)'(issue) - (RA+1)'(resp_acc);
            if (resp_err) err <= 1'b1;
        end
    end
endmodule

// File: doc/coproc_req_queue.md
# coproc_req_queue

Request/response queue between the core's coprocessor issue port and a genfifo-style execution unit such as the MUL/DIV unit. It buffers requests in a DEPTH-entry FIFO and bounds in-flight operations to MAX_INFLIGHT. It captures the unit's single-cycle response pulses into a response FIFO that the core drains with a req/ack handshake. This lets the core stall on the response without losing results.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- MAX_INFLIGHT, 2: maximum issued requests whose response the core has not yet accepted; also the response FIFO depth; power of two, ≥1.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- core_req_i  in  1  core request valid.
- core_rdata_bi  in  req_struct  request payload (instr_code, src0_data, src1_data).
- core_ack_o  out  1  request accepted this cycle when also core_req_i.
- exu_req_o  out  1  request to execution unit.
- exu_rdata_bo  out  req_struct  head-of-queue payload.
- exu_ack_i  in  1  execution unit accepts request.
- exu_resp_req_i  in  1  single-cycle response pulse from execution unit.
- exu_resp_wdata_bi  in  resp_struct  response payload (rd0_wdata).
- core_resp_req_o  out  1  response valid to core.
- core_resp_wdata_bo  out  resp_struct  head response payload.
- core_resp_ack_i  in  1  core accepts response.
- err_o  out  1  sticky protocol error.

## Operation
- Request FIFO: read/write pointers of log2(DEPTH)+1 bits, wrapping modulo 2·DEPTH. Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal.
- core_ack_o = !req_full. The full signal is not pop-aware, so there is no push into a full FIFO even if it pops in the same cycle. push = core_req_i & core_ack_o.
- issue_ok = (inflight < MAX_INFLIGHT).
- exu_req_o = !req_empty & issue_ok. exu_rdata_bo = head entry.
- pop = exu_req_o & exu_ack_i. exu_rdata_bo is stable while exu_req_o is high and exu_ack_i is low.
- inflight counter, width log2(MAX_INFLIGHT)+1:
  - +1 on issue (pop).
  - −1 on core response accept (core_resp_req_o & core_resp_ack_i).
  - Both in the same cycle: unchanged.
- Response FIFO: MAX_INFLIGHT entries, same pointer scheme as the request FIFO.
  - Written on every exu_resp_req_i; never back-pressures the unit.
  - core_resp_req_o = !resp_empty; payload is the head entry.
  - Pop on core_resp_req_o & core_resp_ack_i.
- Overflow is impossible by construction, because responses outstanding plus buffered never exceed inflight ≤ MAX_INFLIGHT.
- err_o is set, and stays set until reset, on either condition:
  - exu_resp_req_i while the response FIFO is full (the write is dropped).
  - exu_resp_req_i while inflight equals the number of buffered responses (a response with nothing outstanding; the write still occurs).
- Ordering: strict FIFO on both paths. Responses are delivered in execution-unit completion order.

## Timing
- Reset values: core_ack_o=1, exu_req_o=0, core_resp_req_o=0, err_o=0, pointers=0, inflight=0. FIFO contents are not reset.
- Reset asserted mid-operation discards all queued requests and responses and clears inflight on the next edge. Responses arriving during or after that reset are dropped without setting err_o in the reset cycle.
- Request latency without bypass: push at cycle N gives exu_req_o=1 at N+1 at the earliest.
- Response latency without bypass: exu_resp_req_i at N gives core_resp_req_o=1 at N+1.
- Throughput: one request per cycle in each direction when not full or throttled.
- Same-cycle push and pop on a non-empty, non-full request FIFO: occupancy unchanged.
- Same-cycle response write and core pop: occupancy unchanged.

## Configuration
- COPROC_QUEUE_BYPASS_EN defined:
  - Request path: when the request FIFO is empty and issue_ok, a core request drives exu_req_o and exu_rdata_bo combinationally in the same cycle. If exu_ack_i is also high, nothing is written; otherwise the request is written normally.
  - Response path: when the response FIFO is empty, exu_resp_req_i drives core_resp_req_o and core_resp_wdata_bo in the same cycle. If core_resp_ack_i is also high, nothing is written.
  - Zero-cycle latency on both paths.
- COPROC_QUEUE_BYPASS_EN undefined: all outputs are driven from registered state only, with one-cycle minimum latency as in Timing.

## Test plan
- Reset, then push 4 requests (instr_code funct3=0..3, src0=2..5, src1=3) with exu_ack_i=0:
  - core_ack_o falls after the 4th push, with DEPTH=4.
  - exu_rdata_bo holds entry 0 unchanged.
- Inflight limit: exu_ack_i=1, core_resp_ack_i=0, 4 queued requests, MAX_INFLIGHT=2:
  - Exactly 2 pops, then exu_req_o=0.
  - Injecting 2 responses (0x6, 0xC) gives core_resp_req_o=1 with 0x6 at the head.
  - Acking 0x6 lets the next request issue the cycle after.
- Ordering under wrap: stream 20 requests with random exu_ack_i and core_resp_ack_i stalls, and the unit echoing src0+src1 → core receives all 20 results in order, with no loss or duplication and err_o=0.
- Protocol error:
  - Pulse exu_resp_req_i with inflight=0 → err_o=1 the next cycle and stays 1.
  - Apply rst_i → err_o=0.
- Reset mid-operation with 3 requests queued and 1 in flight:
  - One rst_i cycle gives exu_req_o=0, core_resp_req_o=0, core_ack_o=1.
  - A late response pulse in the reset cycle is not delivered.
- Bypass:
  - With COPROC_QUEUE_BYPASS_EN defined: push into an empty queue with exu_ack_i=1 → exu_req_o=1 in the same cycle and the FIFO stays empty.
  - Without the macro: exu_req_o=1 one cycle later.
